seq_mult_shift_add: RTL



---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_mult_sign_fix.sv | 16 +
 rtl/seq_mult_shift_add.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shift-add sequential multiplier.
package seq_mult_pkg;

    // Controller states: waiting for operands, iterating, holding the result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter width able to hold every value 0..width.
    function automatic int unsigned f_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_sign_fix.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of the finished product.
module seq_mult_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    // Pass the value through, or negate it modulo 2^W when i_neg is set.
    always_comb begin
        o_data = i_neg ? ('0 - i_data) : i_data;
    end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Radix-2 shift-add multiplier, one WIDTH x WIDTH -> 2*WIDTH product per
// transaction, WIDTH iterations per product, signed or unsigned per request.
// Signed operands are reduced to magnitudes on capture; the sign is restored
// on the final iteration so the datapath itself is purely unsigned.
module seq_mult_shift_add
    import seq_mult_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = f_cnt_w(WIDTH)
) (
    input  logic                 slow_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_iterate;
    logic                 w_last;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [2*WIDTH-1:0]   w_prod_fixed;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_iterate = (r_state == S_BUSY);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_a_neg   = is_signed & a[WIDTH-1];
    assign w_b_neg   = is_signed & b[WIDTH-1];

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) held unsigned.
    seq_mult_sign_fix #(.W(WIDTH)) u_mag_a (
        .i_neg  (w_a_neg),
        .i_data (a),
        .o_data (w_a_mag)
    );

    seq_mult_sign_fix #(.W(WIDTH)) u_mag_b (
        .i_neg  (w_b_neg),
        .i_data (b),
        .o_data (w_b_mag)
    );

    // One iteration: conditional add into the upper half with carry kept,
    // then shift {carry, acc, multiplier} right by one.
    always_comb begin
        w_sum        = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_nxt    = w_sum[WIDTH:1];
        w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
    end

    // The product is signed-corrected straight from the last iteration's
    // shifted value so the result is registered on the same edge.
    seq_mult_sign_fix #(.W(2*WIDTH)) u_fix_result (
        .i_neg  (r_neg),
        .i_data ({w_acc_nxt, w_mplier_nxt}),
        .o_data (w_prod_fixed)
    );

    // State register.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_BUSY;
            S_BUSY:  if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    end

    // Datapath: operand capture, iteration, and result load.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (w_iterate) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_prod_fixed;
            end
        end
    end

    assign result = r_result;

endmodule
